// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the sized RV32 data memory
package dmem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_funct3_e;

  // Store encodings share values with the signed loads.
  localparam mem_funct3_e SB = LB;
  localparam mem_funct3_e SH = LH;
  localparam mem_funct3_e SW = LW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    if (funct3[1:0] == 2'b01 && a[0]) mis = 1'b1;
    if (funct3[1:0] == 2'b10 && a != 2'b00) mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - byte-lane steering for stores and extraction/extension for loads
module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata
);

  logic [31:0] rword_sh;

  always_comb begin
    be       = 4'hF;
    wdata_sh = wdata << {byte_off, 3'b000};
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << byte_off;
      2'b01:   be = 4'b0011 << byte_off;
      default: be = 4'hF;
    endcase
  end

  always_comb begin
    rword_sh = rword >> {byte_off, 3'b000};
    rdata    = 32'h0;
    case (funct3)
      LB:      rdata = {{24{rword_sh[7]}}, rword_sh[7:0]};
      LH:      rdata = {{16{rword_sh[15]}}, rword_sh[15:0]};
      LW:      rdata = rword_sh;
      LBU:     rdata = {24'h0, rword_sh[7:0]};
      LHU:     rdata = {16'h0, rword_sh[15:0]};
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// rtl/dmem_sized.sv - RV32 data memory with req/rsp handshake, sized access, wait states and faults
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  dmem_state_e state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept;

  logic [AW-1:0] idx;
  logic [31:0]   word_addr;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   ld_data;
  logic          out_of_range;
  logic          illegal_f3;
  logic          fault;

  assign idx          = req_addr[AW+1:2];
  assign word_addr    = {2'b00, req_addr[31:2]};
  assign out_of_range = word_addr >= 32'(DEPTH_WORDS);
  assign illegal_f3   = req_we ? (req_funct3 >= 3'b011)
                               : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
  assign fault        = out_of_range || illegal_f3 || is_misaligned(req_funct3, req_addr[1:0]);
  assign rword        = out_of_range ? 32'h0 : mem[idx];

  dmem_align u_align (
    .funct3   (req_funct3),
    .byte_off (req_addr[1:0]),
    .wdata    (req_wdata),
    .rword    (rword),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (ld_data)
  );

  // Array has no reset: committed stores survive rst.
  always_ff @(posedge clk) begin
    if (!rst && accept && req_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'h0;
      rsp_fault <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        rsp_fault <= fault;
        rsp_rdata <= (fault || req_we) ? 32'h0 : ld_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE, RESP: begin
        req_ready  = 1'b1;
        rsp_valid  = (state == RESP);
        accept     = req_valid;
        state_next = IDLE;
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_sized.sv
// tb/tb_dmem_sized.sv - directed self-checking bench for dmem_sized (zero and three wait states)
module tb_dmem_sized;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, v0, we0, rdy0, rv0, rf0;
  logic [2:0]  f0;
  logic [31:0] a0, d0, rd0;
  logic        rst3, v3, we3, rdy3, rv3, rf3;
  logic [2:0]  f3;
  logic [31:0] a3, d3, rd3;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_sized #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_funct3(f0), .req_addr(a0), .req_wdata(d0),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_fault(rf0)
  );

  dmem_sized #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
    .req_funct3(f3), .req_addr(a3), .req_wdata(d3),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_fault(rf3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Single access on the zero-wait instance; samples the response one cycle after accept.
  task automatic acc0(input string tag, input logic we, input logic [2:0] fn,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_flt);
    @(negedge clk);
    v0 = 1'b1; we0 = we; f0 = fn; a0 = a; d0 = d;
    @(posedge clk); #1;
    v0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, {31'h0, rv0}, 32'h1);
    check({tag, "_rdata"}, rd0, exp_rd);
    check({tag, "_fault"}, {31'h0, rf0}, {31'h0, exp_flt});
  endtask

  int lat, seen;
  logic got_rsp;

  initial begin
    rst0 = 1'b1; v0 = 1'b0; we0 = 1'b0; f0 = 3'b0; a0 = 32'h0; d0 = 32'h0;
    rst3 = 1'b1; v3 = 1'b0; we3 = 1'b0; f3 = 3'b0; a3 = 32'h0; d3 = 32'h0;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'h0, rv0}, 32'h0);
    check("rst_rdata", rd0, 32'h0);
    check("rst_fault", {31'h0, rf0}, 32'h0);
    check("rst_ready", {31'h0, rdy0}, 32'h1);
    check("rst3_valid", {31'h0, rv3}, 32'h0);

    acc0("sw08", 1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0);
    acc0("lw08", 1'b0, 3'b010, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("pulse_end", {31'h0, rv0}, 32'h0);

    acc0("sb0d",  1'b1, 3'b000, 32'h0D, 32'h00000080, 32'h0, 1'b0);
    acc0("lb0d",  1'b0, 3'b000, 32'h0D, 32'h0, 32'hFFFFFF80, 1'b0);
    acc0("lbu0d", 1'b0, 3'b100, 32'h0D, 32'h0, 32'h00000080, 1'b0);
    acc0("lw0c",  1'b0, 3'b010, 32'h0C, 32'h0, 32'h00008000, 1'b0);

    acc0("sh12",  1'b1, 3'b001, 32'h12, 32'h0000BEEF, 32'h0, 1'b0);
    acc0("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0);
    acc0("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000BEEF, 1'b0);
    acc0("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hBEEF0000, 1'b0);

    acc0("lw06_mis",  1'b0, 3'b010, 32'h06, 32'h0, 32'h0, 1'b1);
    acc0("lh13_mis",  1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1);
    acc0("ld_f3_011", 1'b0, 3'b011, 32'h08, 32'h0, 32'h0, 1'b1);
    acc0("ld_f3_110", 1'b0, 3'b110, 32'h08, 32'h0, 32'h0, 1'b1);
    acc0("sw100_oor", 1'b1, 3'b010, 32'h100, 32'h11223344, 32'h0, 1'b1);
    acc0("lw00_keep", 1'b0, 3'b010, 32'h00, 32'h0, 32'h0, 1'b0);
    acc0("st_f3_100", 1'b1, 3'b100, 32'h08, 32'h55555555, 32'h0, 1'b1);
    acc0("lw08_keep", 1'b0, 3'b010, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0);

    // Back-to-back store then load of the same word.
    @(negedge clk);
    v0 = 1'b1; we0 = 1'b1; f0 = 3'b010; a0 = 32'h20; d0 = 32'h12345678;
    @(posedge clk); #1;
    we0 = 1'b0;
    @(negedge clk);
    check("b2b_sw_valid", {31'h0, rv0}, 32'h1);
    check("b2b_ready", {31'h0, rdy0}, 32'h1);
    @(posedge clk); #1;
    v0 = 1'b0;
    @(negedge clk);
    check("b2b_lw_valid", {31'h0, rv0}, 32'h1);
    check("b2b_lw_rdata", rd0, 32'h12345678);
    acc0("sh21_mis", 1'b1, 3'b001, 32'h21, 32'h0000AAAA, 32'h0, 1'b1);
    acc0("lw20_keep", 1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 1'b0);

    // Three wait states, with a second request held during the wait.
    @(negedge clk);
    v3 = 1'b1; we3 = 1'b1; f3 = 3'b010; a3 = 32'h04; d3 = 32'hCAFEF00D;
    @(posedge clk); #1;
    we3 = 1'b0; d3 = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("w3_ready_low", {31'h0, rdy3}, 32'h0);
      check("w3_no_rsp", {31'h0, rv3}, 32'h0);
    end
    @(negedge clk);
    check("w3_rsp_at4", {31'h0, rv3}, 32'h1);
    check("w3_ready_hi", {31'h0, rdy3}, 32'h1);
    check("w3_sw_fault", {31'h0, rf3}, 32'h0);
    @(posedge clk); #1;
    v3 = 1'b0;
    lat = 0; got_rsp = 1'b0;
    while (lat < 10 && !got_rsp) begin
      @(negedge clk);
      lat++;
      if (rv3) got_rsp = 1'b1;
    end
    check("w3_lw_lat", 32'(lat), 32'd4);
    check("w3_lw_rdata", rd3, 32'hCAFEF00D);

    // Reset during WAIT drops the pending load response.
    @(negedge clk);
    v3 = 1'b1; we3 = 1'b0; f3 = 3'b010; a3 = 32'h04;
    @(posedge clk); #1;
    v3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv3) seen++;
    end
    check("rst_drop", 32'(seen), 32'd0);
    @(negedge clk);
    v3 = 1'b1; we3 = 1'b0; f3 = 3'b010; a3 = 32'h04;
    @(posedge clk); #1;
    v3 = 1'b0;
    lat = 0; got_rsp = 1'b0;
    while (lat < 10 && !got_rsp) begin
      @(negedge clk);
      lat++;
      if (rv3) got_rsp = 1'b1;
    end
    check("rst_keep_lat", 32'(lat), 32'd4);
    check("rst_keep_rdata", rd3, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
